// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl
//   Owns the snake's segment coordinates on the logic grid. Each accepted
//   move strobe advances the head one cell, with wrap-around at the grid
//   edges, and applies any pending growth. The whole body is then streamed
//   out one segment per cycle for the downstream apple/collision checker.
//   A head landing on any body segment raises a sticky game_over.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   tick         one-cycle move strobe
//   dir_vld      dir_req valid this cycle
//   dir_req      requested direction: 00 right, 01 left, 10 up, 11 down
//   is_eat       apple eaten; latched until the next move consumes it
//   x_snake_cur  streamed segment x
//   y_snake_cur  streamed segment y
//   length       current segment count, 1..MAX_LEN
//   vld          pulse: a move was committed and a new frame begins
//   vld_start    head segment is on x/y_snake_cur
//   vld_t        a body segment (index > 0) is on x/y_snake_cur
//   is_end       the segment on x/y_snake_cur is the last one
//   pixel_done   pulse in the cycle after the last segment
//   game_over    sticky self-collision flag
module snake_body_ctrl #(
  parameter int                       H_LOGIC_WIDTH = 5,
  parameter int                       V_LOGIC_WIDTH = 5,
  parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX   = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX   = 5'd23,
  parameter int                       MAX_LEN       = 64,
  parameter logic [H_LOGIC_WIDTH-1:0] INIT_X        = 5'd2,
  parameter logic [V_LOGIC_WIDTH-1:0] INIT_Y        = 5'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     dir_vld,
  input  logic [1:0]               dir_req,
  input  logic                     is_eat,
  output logic [H_LOGIC_WIDTH-1:0] x_snake_cur,
  output logic [V_LOGIC_WIDTH-1:0] y_snake_cur,
  output logic [9:0]               length,
  output logic                     vld,
  output logic                     vld_start,
  output logic                     vld_t,
  output logic                     is_end,
  output logic                     pixel_done,
  output logic                     game_over
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [9:0] MAX_LEN_L = 10'(MAX_LEN);

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    STREAM,
    DONE
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [9:0]               idx;
  logic [9:0]               idx_next;
  logic [9:0]               length_next;
  logic [1:0]               dir;
  logic [1:0]               pending_dir;
  logic                     eat_pending;
  logic [H_LOGIC_WIDTH-1:0] seg_x [MAX_LEN];
  logic [V_LOGIC_WIDTH-1:0] seg_y [MAX_LEN];
  logic [H_LOGIC_WIDTH-1:0] head_x_new;
  logic [V_LOGIC_WIDTH-1:0] head_y_new;
  logic                     dir_accept;
  logic                     collide;

  // Next head position from the current head and the direction that this
  // move will commit. Up is toward smaller y.
  always_comb begin
    head_x_new = seg_x[0];
    head_y_new = seg_y[0];
    case (pending_dir)
      DIR_RIGHT: head_x_new = (seg_x[0] == H_LOGIC_MAX) ? '0 : seg_x[0] + 1'b1;
      DIR_LEFT:  head_x_new = (seg_x[0] == '0) ? H_LOGIC_MAX : seg_x[0] - 1'b1;
      DIR_UP:    head_y_new = (seg_y[0] == '0) ? V_LOGIC_MAX : seg_y[0] - 1'b1;
      DIR_DOWN:  head_y_new = (seg_y[0] == V_LOGIC_MAX) ? '0 : seg_y[0] + 1'b1;
      default: begin
        head_x_new = seg_x[0];
        head_y_new = seg_y[0];
      end
    endcase
  end

  // A reversal flips bit 0 while keeping the axis bit. The check is against
  // the committed direction, so several requests in one idle window cannot
  // sneak a reversal through an intermediate turn's pending value.
  always_comb begin
    dir_accept = dir_vld &&
                 !((length > 10'd1) && (dir_req[1] == dir[1]) && (dir_req[0] != dir[0]));
  end

  // Segment storage is stable throughout STREAM, so the segment currently
  // being shown can be compared directly against the head.
  always_comb begin
    collide = (state == STREAM) && (idx != '0) &&
              (seg_x[idx[IDX_W-1:0]] == seg_x[0]) &&
              (seg_y[idx[IDX_W-1:0]] == seg_y[0]);
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    length_next = length;
    case (state)
      IDLE: begin
        if (tick && !game_over) state_next = MOVE;
      end
      MOVE: begin
        state_next = STREAM;
        idx_next   = '0;
        if (eat_pending && (length < MAX_LEN_L)) length_next = length + 10'd1;
      end
      STREAM: begin
        if (idx == length - 10'd1) state_next = DONE;
        else                       idx_next   = idx + 10'd1;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Strobes and the streamed coordinate are registered from the next-state
  // view so that each lands in the same cycle as the state it describes.
  // When leaving MOVE the head register is being rewritten on the same edge,
  // so the freshly computed head is streamed rather than seg[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      length      <= 10'd1;
      idx         <= '0;
      dir         <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      eat_pending <= 1'b0;
      game_over   <= 1'b0;
      vld         <= 1'b0;
      vld_start   <= 1'b0;
      vld_t       <= 1'b0;
      is_end      <= 1'b0;
      pixel_done  <= 1'b0;
      x_snake_cur <= '0;
      y_snake_cur <= '0;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x[k] <= (k == 0) ? INIT_X : '0;
        seg_y[k] <= (k == 0) ? INIT_Y : '0;
      end
    end else begin
      length <= length_next;
      idx    <= idx_next;

      if (dir_accept) pending_dir <= dir_req;

      // An eat seen during MOVE itself is kept for the following move.
      if (state == MOVE) begin
        dir         <= pending_dir;
        eat_pending <= is_eat;
        for (int k = MAX_LEN - 1; k > 0; k--) begin
          seg_x[k] <= seg_x[k-1];
          seg_y[k] <= seg_y[k-1];
        end
        seg_x[0] <= head_x_new;
        seg_y[0] <= head_y_new;
      end else if (is_eat) begin
        eat_pending <= 1'b1;
      end

      if (collide) game_over <= 1'b1;

      vld        <= (state_next == MOVE);
      pixel_done <= (state_next == DONE);
      vld_start  <= (state_next == STREAM) && (idx_next == '0);
      vld_t      <= (state_next == STREAM) && (idx_next != '0);
      is_end     <= (state_next == STREAM) && (idx_next == length_next - 10'd1);

      if (state == MOVE) begin
        x_snake_cur <= head_x_new;
        y_snake_cur <= head_y_new;
      end else if (state_next == STREAM) begin
        x_snake_cur <= seg_x[idx_next[IDX_W-1:0]];
        y_snake_cur <= seg_y[idx_next[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb_snake_body_ctrl
//   Directed bench for snake_body_ctrl. Inputs change and outputs are
//   sampled on the falling clock edge; every expected value is worked out
//   by hand from the snake's path.
module tb_snake_body_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       dir_vld;
  logic [1:0] dir_req;
  logic       is_eat;
  logic [4:0] x_snake_cur;
  logic [4:0] y_snake_cur;
  logic [9:0] length;
  logic       vld;
  logic       vld_start;
  logic       vld_t;
  logic       is_end;
  logic       pixel_done;
  logic       game_over;

  int vectors     = 0;
  int miscompares = 0;

  // Capture of the most recent streamed frame.
  logic [4:0] sx [64];
  logic [4:0] sy [64];
  int         slen;
  int         start_cnt;
  int         t_cnt;
  int         end_pos;

  localparam logic [1:0] D_RIGHT = 2'b00;
  localparam logic [1:0] D_LEFT  = 2'b01;
  localparam logic [1:0] D_UP    = 2'b10;
  localparam logic [1:0] D_DOWN  = 2'b11;

  snake_body_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .dir_vld     (dir_vld),
    .dir_req     (dir_req),
    .is_eat      (is_eat),
    .x_snake_cur (x_snake_cur),
    .y_snake_cur (y_snake_cur),
    .length      (length),
    .vld         (vld),
    .vld_start   (vld_start),
    .vld_t       (vld_t),
    .is_end      (is_end),
    .pixel_done  (pixel_done),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and return at the next falling edge, where
  // the outputs reflect the rising edge that consumed those inputs.
  task automatic applyStimulus(input logic r, input logic t, input logic dv,
                               input logic [1:0] dr, input logic e);
    rst     = r;
    tick    = t;
    dir_vld = dv;
    dir_req = dr;
    is_eat  = e;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setDir(input logic [1:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic pulseEat();
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b1);
  endtask

  // One full move: tick, expect vld, capture the stream until pixel_done,
  // then one more cycle so the controller is back in IDLE.
  task automatic runFrame();
    applyStimulus(1'b0, 1'b1, 1'b0, D_RIGHT, 1'b0);
    checkOutput("move_vld", 32'(vld), 32'd1);
    slen      = 0;
    start_cnt = 0;
    t_cnt     = 0;
    end_pos   = -1;
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    for (int c = 0; c < 100; c++) begin
      if (pixel_done) break;
      if (vld_start || vld_t) begin
        if (slen < 64) begin
          sx[slen] = x_snake_cur;
          sy[slen] = y_snake_cur;
        end
        if (vld_start) start_cnt++;
        if (vld_t)     t_cnt++;
        if (is_end)    end_pos = slen;
        slen++;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    end
    checkOutput("frame_pixel_done", 32'(pixel_done), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] d;

    // Reset state.
    applyStimulus(1'b1, 1'b0, 1'b0, D_RIGHT, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, D_RIGHT, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    checkOutput("rst_length", 32'(length), 32'd1);
    checkOutput("rst_strobes", {27'd0, vld, vld_start, vld_t, is_end, pixel_done}, 32'd0);
    checkOutput("rst_game_over", 32'(game_over), 32'd0);
    checkOutput("rst_xy", {22'd0, x_snake_cur, y_snake_cur}, 32'd0);

    // First move, cycle by cycle: head (2,0) -> (3,0), length 1.
    applyStimulus(1'b0, 1'b1, 1'b0, D_RIGHT, 1'b0);
    checkOutput("t1_vld", 32'(vld), 32'd1);
    checkOutput("t1_no_start", 32'(vld_start), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    checkOutput("t2_vld_low", 32'(vld), 32'd0);
    checkOutput("t2_start_end", {30'd0, vld_start, is_end}, 32'd3);
    checkOutput("t2_vld_t", 32'(vld_t), 32'd0);
    checkOutput("t2_head_x", 32'(x_snake_cur), 32'd3);
    checkOutput("t2_head_y", 32'(y_snake_cur), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    checkOutput("t3_pixel_done", 32'(pixel_done), 32'd1);
    checkOutput("t3_start_low", 32'(vld_start), 32'd0);
    checkOutput("t3_hold_x", 32'(x_snake_cur), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    checkOutput("t4_pixel_done_low", 32'(pixel_done), 32'd0);
    checkOutput("t4_length", 32'(length), 32'd1);

    // Growth: one eat pulse, then three moves -> length 2 from the first.
    pulseEat();
    runFrame();
    checkOutput("grow_length", 32'(length), 32'd2);
    checkOutput("grow_slen", 32'(slen), 32'd2);
    checkOutput("grow_head", {22'd0, sx[0], sy[0]}, {22'd0, 5'd4, 5'd0});
    checkOutput("grow_tail", {22'd0, sx[1], sy[1]}, {22'd0, 5'd3, 5'd0});
    checkOutput("grow_start_cnt", 32'(start_cnt), 32'd1);
    checkOutput("grow_t_cnt", 32'(t_cnt), 32'd1);
    checkOutput("grow_end_pos", 32'(end_pos), 32'd1);
    runFrame();
    runFrame();
    checkOutput("grow_length_hold", 32'(length), 32'd2);
    checkOutput("grow_head3", {22'd0, sx[0], sy[0]}, {22'd0, 5'd6, 5'd0});

    // Right-edge wrap: (6,0) down to (6,5), right to (31,5), then to (0,5).
    setDir(D_DOWN);
    for (int i = 0; i < 5; i++) runFrame();
    setDir(D_RIGHT);
    for (int i = 0; i < 25; i++) runFrame();
    checkOutput("pre_wrap_head", {22'd0, sx[0], sy[0]}, {22'd0, 5'd31, 5'd5});
    runFrame();
    checkOutput("wrap_x_head", {22'd0, sx[0], sy[0]}, {22'd0, 5'd0, 5'd5});
    checkOutput("wrap_x_tail", {22'd0, sx[1], sy[1]}, {22'd0, 5'd31, 5'd5});

    // Top-edge wrap: up to (0,0), right to (4,0), then up to (4,23).
    setDir(D_UP);
    for (int i = 0; i < 5; i++) runFrame();
    setDir(D_RIGHT);
    for (int i = 0; i < 4; i++) runFrame();
    setDir(D_UP);
    runFrame();
    checkOutput("wrap_y_head", {22'd0, sx[0], sy[0]}, {22'd0, 5'd4, 5'd23});
    checkOutput("wrap_y_tail", {22'd0, sx[1], sy[1]}, {22'd0, 5'd4, 5'd0});

    // Length 3 moving right; a left request is a reversal and is ignored.
    pulseEat();
    setDir(D_RIGHT);
    runFrame();
    checkOutput("len3_length", 32'(length), 32'd3);
    setDir(D_LEFT);
    runFrame();
    checkOutput("rev_head", {22'd0, sx[0], sy[0]}, {22'd0, 5'd6, 5'd23});
    checkOutput("rev_tail", {22'd0, sx[2], sy[2]}, {22'd0, 5'd4, 5'd23});
    // Down then up in one window: up is checked against committed right.
    setDir(D_DOWN);
    setDir(D_UP);
    runFrame();
    checkOutput("last_req_head", {22'd0, sx[0], sy[0]}, {22'd0, 5'd6, 5'd22});
    checkOutput("last_req_seg1", {22'd0, sx[1], sy[1]}, {22'd0, 5'd6, 5'd23});

    // Reset mid-stream at idx 2 of a length-3 frame (6,21),(6,22),(6,23).
    applyStimulus(1'b0, 1'b1, 1'b0, D_RIGHT, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    checkOutput("idx2_xy", {22'd0, x_snake_cur, y_snake_cur}, {22'd0, 5'd6, 5'd23});
    checkOutput("idx2_t_end", {30'd0, vld_t, is_end}, 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, D_RIGHT, 1'b0);
    checkOutput("midrst_strobes", {27'd0, vld, vld_start, vld_t, is_end, pixel_done}, 32'd0);
    checkOutput("midrst_length", 32'(length), 32'd1);
    checkOutput("midrst_xy", {22'd0, x_snake_cur, y_snake_cur}, 32'd0);
    runFrame();
    checkOutput("midrst_head", {22'd0, sx[0], sy[0]}, {22'd0, 5'd3, 5'd0});
    checkOutput("midrst_slen", 32'(slen), 32'd1);

    // Self-collision: grow to 5 along row 0, then down/left/up.
    for (int i = 0; i < 4; i++) begin
      pulseEat();
      runFrame();
    end
    checkOutput("col_length", 32'(length), 32'd5);
    checkOutput("col_tail", {22'd0, sx[4], sy[4]}, {22'd0, 5'd3, 5'd0});
    setDir(D_DOWN);
    runFrame();
    setDir(D_LEFT);
    runFrame();
    checkOutput("col_not_yet", 32'(game_over), 32'd0);
    setDir(D_UP);
    runFrame();
    checkOutput("col_slen", 32'(slen), 32'd5);
    checkOutput("col_head", {22'd0, sx[0], sy[0]}, {22'd0, 5'd6, 5'd0});
    checkOutput("col_seg4", {22'd0, sx[4], sy[4]}, {22'd0, 5'd6, 5'd0});
    checkOutput("col_game_over", 32'(game_over), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, D_RIGHT, 1'b0);
    checkOutput("go_tick_dropped", 32'(vld), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, D_RIGHT, 1'b0);
    checkOutput("go_no_stream", {29'd0, vld, vld_start, vld_t}, 32'd0);
    checkOutput("go_sticky", 32'(game_over), 32'd1);

    // Saturation: serpentine over rows 0..3 with an eat before each of 70
    // moves; length tops out at 64 and the head ends at (15,3).
    applyStimulus(1'b1, 1'b0, 1'b0, D_RIGHT, 1'b0);
    checkOutput("sat_rst_game_over", 32'(game_over), 32'd0);
    for (int m = 0; m < 70; m++) begin
      if ((m % 21) == 20)         d = D_DOWN;
      else if (((m / 21) % 2) == 0) d = D_RIGHT;
      else                        d = D_LEFT;
      setDir(d);
      pulseEat();
      runFrame();
    end
    checkOutput("sat_length", 32'(length), 32'd64);
    checkOutput("sat_slen", 32'(slen), 32'd64);
    checkOutput("sat_end_pos", 32'(end_pos), 32'd63);
    checkOutput("sat_head", {22'd0, sx[0], sy[0]}, {22'd0, 5'd15, 5'd3});
    checkOutput("sat_game_over", 32'(game_over), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snake_body_ctrl.md
Name: snake_body_ctrl

Overview:
- Upstream producer for the apple/collision checker.
- Holds the snake's segment coordinates on the 32x24 logic grid.
- On each move strobe, advances the head with wrap-around and applies any growth earned by `is_eat`.
- Then streams every segment out serially, one per cycle, with framing strobes (`vld`, `vld_start`, `vld_t`, `is_end`, `pixel_done`). It also flags self-collision as `game_over`.

Parameters:
H_LOGIC_WIDTH, 5, x coordinate width
V_LOGIC_WIDTH, 5, y coordinate width
H_LOGIC_MAX, 5'd31, largest x cell
V_LOGIC_MAX, 5'd23, largest y cell
MAX_LEN, 64, segment storage depth; length saturates here
INIT_X, 5'd2, head x after reset
INIT_Y, 5'd0, head y after reset

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle move strobe from the game-speed divider
dir_vld  in  1  dir_req is valid this cycle
dir_req  in  2  00 right, 01 left, 10 up, 11 down
is_eat  in  1  apple eaten; level or pulse, sampled every cycle
x_snake_cur  out  H_LOGIC_WIDTH  streamed segment x
y_snake_cur  out  V_LOGIC_WIDTH  streamed segment y
length  out  10  current segment count, 1..MAX_LEN
vld  out  1  one-cycle pulse: move committed, new frame begins
vld_start  out  1  segment 0 (head) valid on x/y_snake_cur
vld_t  out  1  segment k>0 valid on x/y_snake_cur
is_end  out  1  current streamed segment is the last one
pixel_done  out  1  one-cycle pulse after the last segment
game_over  out  1  sticky: head hit body

Behaviour:
- Reset (sync, overrides everything including mid-stream):
  - state=IDLE; length=1; seg[0]=(INIT_X, INIT_Y); other seg entries=0.
  - dir=right, pending dir=right, eat_pending=0, idx=0.
  - All strobes 0; x/y_snake_cur=0; game_over=0.
- Direction: on dir_vld, pending_dir<=dir_req, except a 180-degree reversal of the committed dir when length>1 (ignored). Accepted in any state; applied at the next MOVE. A later dir_vld before MOVE overwrites.
- Growth: is_eat=1 in any cycle sets eat_pending. Cleared only in MOVE, where it is consumed.
- FSM states: IDLE, MOVE, STREAM, DONE.
- IDLE:
  - tick=1 and game_over=0 -> MOVE next cycle.
  - tick while not in IDLE, or while game_over=1, is dropped.
- MOVE (exactly 1 cycle):
  - vld=1; dir<=pending_dir.
  - New head computed from seg[0]:
    - x+1 wraps H_LOGIC_MAX->0; x-1 wraps 0->H_LOGIC_MAX.
    - y+1 wraps V_LOGIC_MAX->0; y-1 wraps 0->V_LOGIC_MAX.
    - Up = y-1.
  - seg[k]<=seg[k-1] for k=1..MAX_LEN-1; seg[0]<=new head.
  - If eat_pending and length<MAX_LEN: length<=length+1 (new tail = old tail position). At MAX_LEN, growth is silently discarded.
  - idx<=0 -> STREAM.
- STREAM (length cycles, one segment per cycle):
  - Outputs registered: x/y_snake_cur=seg[idx].
  - vld_start=(idx==0); vld_t=(idx!=0).
  - is_end=(idx==length-1). For length==1, vld_start and is_end are high in the same cycle.
  - If idx!=0 and seg[idx]==seg[0]: game_over<=1. The stream still completes.
  - idx++; after the idx==length-1 cycle -> DONE.
- DONE (1 cycle): pixel_done=1 -> IDLE.
- Timing: tick in IDLE at cycle T gives:
  - vld at T+1.
  - Head at T+2.
  - Last segment at T+1+length.
  - pixel_done at T+2+length.
  - Ready for tick at T+3+length.
- Outside STREAM: x/y_snake_cur hold their last value; vld_start, vld_t and is_end are 0.
- game_over clears only on rst.

Test Plan:
- Reset, then tick with no dir -> vld at T+1; head (3,0) with vld_start=is_end=1 at T+2; pixel_done at T+3; length=1.
- Head at (31,5) moving right, tick -> head (0,5). Head at (4,0) dir up, tick -> head (4,23).
- is_eat pulse, then 3 ticks -> length 2 after tick 1. Stream shows head (4,0), tail (3,0); vld_t=1 and is_end=1 on the tail only.
- Length 3 moving right, dir_vld with left -> ignored, head keeps x+1. dir_vld down then up in the same IDLE window -> up (reversal check is against committed dir) applied at next MOVE.
- Grow to length 5, then issue right/down/left/up -> head lands on seg[4]; game_over=1 after stream; further ticks produce no vld.
- Assert rst during STREAM (idx=2) -> next cycle state IDLE, all strobes 0, length=1, head (2,0); length MAX_LEN with is_eat -> length stays 64.
